axi_fb_sram: RTL and testbench

AXI_FB_SRAM -- requirements
Module: axi_fb_sram

---
 rtl/axi_fb_sram.sv | 215 +++++++++++++++++++++
 tb/tb_axi_fb_sram.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fb_sram.sv
// AXI4 slave backed by a byte-lane SRAM for framebuffer storage: 64-bit INCR bursts,
// independent read and write channels, registered read data with one-cycle latency.
module axi_fb_sram #(
    parameter int DEPTH_LOG2 = 18,
    parameter int RLAT       = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [63:0] io_slave_wdata,
    input  logic [7:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [63:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t              r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [3:0]            r_rid;
    logic [7:0]            r_rcnt;
    logic [DEPTH_LOG2-1:0] r_ridx;

    w_state_t              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [3:0]            r_bid;
    logic [7:0]            r_wlen;
    logic [8:0]            r_wcnt;
    logic                  r_werr;
    logic [DEPTH_LOG2-1:0] r_widx;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                  w_unused;

    assign w_ar_hs    = io_slave_arvalid & r_arready;
    assign w_r_hs     = io_slave_rready & r_rvalid;
    assign w_aw_hs    = io_slave_awvalid & r_awready;
    assign w_w_hs     = io_slave_wvalid & r_wready;
    assign w_b_hs     = io_slave_bready & r_bvalid;
    assign w_in_range = ~r_werr & (r_wcnt <= {1'b0, r_wlen});
    assign w_wr_en    = w_w_hs & w_in_range & ~reset;

    // Read data is fetched one beat ahead: at the AR handshake and at every non-final R handshake.
    assign w_rd_en  = w_ar_hs | (w_r_hs & ~r_rlast);
    assign w_rd_idx = w_ar_hs ? io_slave_araddr[DEPTH_LOG2+2:3] : r_ridx;

    assign w_unused = ^{io_slave_araddr[31:DEPTH_LOG2+3], io_slave_araddr[2:0],
                        io_slave_awaddr[31:DEPTH_LOG2+3], io_slave_awaddr[2:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= 4'd0;
            r_rcnt    <= 8'd0;
            r_ridx    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rlast   <= (io_slave_arlen == 8'd0);
                        r_rcnt    <= io_slave_arlen;
                        r_rid     <= io_slave_arid;
                        r_ridx    <= io_slave_araddr[DEPTH_LOG2+2:3] + IDX_ONE;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rstate  <= R_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rcnt  <= r_rcnt - 8'd1;
                            r_rlast <= (r_rcnt == 8'd1);
                            r_ridx  <= r_ridx + IDX_ONE;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate  <= W_ADDR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'd0;
            r_bid     <= 4'd0;
            r_wlen    <= 8'd0;
            r_wcnt    <= 9'd0;
            r_werr    <= 1'b0;
            r_widx    <= '0;
        end else begin
            case (r_wstate)
                W_ADDR: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_widx    <= io_slave_awaddr[DEPTH_LOG2+2:3];
                        r_wlen    <= io_slave_awlen;
                        r_bid     <= io_slave_awid;
                        r_wcnt    <= 9'd0;
                        r_werr    <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_widx <= r_widx + IDX_ONE;
                        r_wcnt <= r_wcnt + 9'd1;
                        if (!w_in_range) begin
                            r_werr <= 1'b1;
                        end
                        // Overrun beats make r_wcnt exceed r_wlen, so one compare covers both errors.
                        if (io_slave_wlast) begin
                            r_wstate <= W_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || (r_wcnt != {1'b0, r_wlen})) ? 2'd2 : 2'd0;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_wstate  <= W_ADDR;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'd0;
                        r_awready <= 1'b1;
                    end
                end
                default: r_wstate <= W_ADDR;
            endcase
        end
    end

    genvar gi;
    if (RLAT == 1) begin : g_rlat1
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;
            always_ff @(posedge clock) begin
                if (w_wr_en && io_slave_wstrb[gi]) begin
                    r_mem[r_widx] <= io_slave_wdata[gi*8 +: 8];
                end
                if (w_rd_en) begin
                    r_q <= r_mem[w_rd_idx];
                end
            end
            assign io_slave_rdata[gi*8 +: 8] = r_q;
        end
    end else begin : g_rlat_unsupported
        assign io_slave_rdata = '0;
    end

    assign io_slave_awready = r_awready;
    assign io_slave_wready  = r_wready;
    assign io_slave_bvalid  = r_bvalid;
    assign io_slave_bresp   = r_bresp;
    assign io_slave_bid     = r_bid;
    assign io_slave_arready = r_arready;
    assign io_slave_rvalid  = r_rvalid;
    assign io_slave_rresp   = 2'd0;
    assign io_slave_rlast   = r_rlast;
    assign io_slave_rid     = r_rid;
endmodule

// File: tb/tb_axi_fb_sram.sv
// Directed plus randomized bench for axi_fb_sram with a word-array reference model.
module tb_axi_fb_sram;
    localparam int DL2   = 18;
    localparam int DEPTH = 1 << DL2;
    localparam int TMO   = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_slave_awready;
    logic        io_slave_awvalid;
    logic [31:0] io_slave_awaddr;
    logic [3:0]  io_slave_awid;
    logic [7:0]  io_slave_awlen;
    logic        io_slave_wready;
    logic        io_slave_wvalid;
    logic [63:0] io_slave_wdata;
    logic [7:0]  io_slave_wstrb;
    logic        io_slave_wlast;
    logic        io_slave_bready;
    logic        io_slave_bvalid;
    logic [1:0]  io_slave_bresp;
    logic [3:0]  io_slave_bid;
    logic        io_slave_arready;
    logic        io_slave_arvalid;
    logic [31:0] io_slave_araddr;
    logic [3:0]  io_slave_arid;
    logic [7:0]  io_slave_arlen;
    logic        io_slave_rready;
    logic        io_slave_rvalid;
    logic [1:0]  io_slave_rresp;
    logic [63:0] io_slave_rdata;
    logic        io_slave_rlast;
    logic [3:0]  io_slave_rid;

    axi_fb_sram #(.DEPTH_LOG2(DL2), .RLAT(1)) dut (
        .clock(clock), .reset(reset),
        .io_slave_awready(io_slave_awready), .io_slave_awvalid(io_slave_awvalid),
        .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid), .io_slave_awlen(io_slave_awlen),
        .io_slave_wready(io_slave_wready), .io_slave_wvalid(io_slave_wvalid), .io_slave_wdata(io_slave_wdata),
        .io_slave_wstrb(io_slave_wstrb), .io_slave_wlast(io_slave_wlast),
        .io_slave_bready(io_slave_bready), .io_slave_bvalid(io_slave_bvalid),
        .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
        .io_slave_arready(io_slave_arready), .io_slave_arvalid(io_slave_arvalid),
        .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid), .io_slave_arlen(io_slave_arlen),
        .io_slave_rready(io_slave_rready), .io_slave_rvalid(io_slave_rvalid), .io_slave_rresp(io_slave_rresp),
        .io_slave_rdata(io_slave_rdata), .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [63:0] mdl [int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mget(input int k);
        if (mdl.exists(k)) return mdl[k];
        return 64'd0;
    endfunction

    task automatic mput(input int k, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        w = mget(k);
        for (int i = 0; i < 8; i++) begin
            if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
        end
        mdl[k] = w;
    endtask

    function automatic logic [31:0] waddr(input int idx);
        return 32'(idx) << 3;
    endfunction

    // dmode: 0 = beat index, 1 = random, 2 = all zeros, 3 = all ones
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input int nbeats, input logic [7:0] strb, input int dmode, input string tag);
        int cnt;
        int idx;
        logic [63:0] d;
        idx = int'(addr[DL2+2:3]);
        @(negedge clock);
        io_slave_awvalid = 1'b1;
        io_slave_awaddr  = addr;
        io_slave_awid    = id;
        io_slave_awlen   = 8'(len);
        cnt = 0;
        while (io_slave_awready !== 1'b1 && cnt < TMO) begin
            @(negedge clock);
            cnt++;
        end
        chk({tag, " aw_wait"}, 64'(cnt < TMO), 64'd1);
        @(negedge clock);
        io_slave_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            case (dmode)
                0: d = 64'(b);
                1: d = {$urandom, $urandom};
                2: d = 64'd0;
                default: d = {64{1'b1}};
            endcase
            io_slave_wvalid = 1'b1;
            io_slave_wdata  = d;
            io_slave_wstrb  = strb;
            io_slave_wlast  = (b == nbeats - 1);
            cnt = 0;
            while (io_slave_wready !== 1'b1 && cnt < TMO) begin
                @(negedge clock);
                cnt++;
            end
            chk($sformatf("%s w_wait b%0d", tag, b), 64'(cnt < TMO), 64'd1);
            if (b <= len) mput((idx + b) % DEPTH, d, strb);
            @(negedge clock);
        end
        io_slave_wvalid = 1'b0;
        io_slave_wlast  = 1'b0;
        io_slave_bready = 1'b1;
        cnt = 0;
        while (io_slave_bvalid !== 1'b1 && cnt < TMO) begin
            @(negedge clock);
            cnt++;
        end
        chk({tag, " b_wait"}, 64'(cnt < TMO), 64'd1);
        chk({tag, " bresp"}, 64'(io_slave_bresp), (nbeats == len + 1) ? 64'd0 : 64'd2);
        chk({tag, " bid"}, 64'(io_slave_bid), 64'(id));
        @(negedge clock);
        io_slave_bready = 1'b0;
        chk({tag, " bvalid_drop"}, 64'(io_slave_bvalid), 64'd0);
        chk({tag, " awready_back"}, 64'(io_slave_awready), 64'd1);
        $display("WRITE %s idx=%0d len=%0d beats=%0d strb=%02h", tag, idx, len, nbeats, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input bit stall, input string tag);
        int cnt;
        int idx;
        int b;
        int cyc;
        idx = int'(addr[DL2+2:3]);
        @(negedge clock);
        io_slave_arvalid = 1'b1;
        io_slave_araddr  = addr;
        io_slave_arid    = id;
        io_slave_arlen   = 8'(len);
        cnt = 0;
        while (io_slave_arready !== 1'b1 && cnt < TMO) begin
            @(negedge clock);
            cnt++;
        end
        chk({tag, " ar_wait"}, 64'(cnt < TMO), 64'd1);
        @(negedge clock);
        io_slave_arvalid = 1'b0;
        chk({tag, " latency"}, 64'(io_slave_rvalid), 64'd1);
        b = 0;
        cyc = 0;
        while (b <= len && cyc < 2 * (len + 1) + TMO) begin
            io_slave_rready = stall ? (cyc % 2 == 0) : 1'b1;
            chk($sformatf("%s rvalid b%0d", tag, b), 64'(io_slave_rvalid), 64'd1);
            chk($sformatf("%s rdata b%0d", tag, b), io_slave_rdata, mget((idx + b) % DEPTH));
            chk($sformatf("%s rlast b%0d", tag, b), 64'(io_slave_rlast), 64'(b == len));
            chk($sformatf("%s rid b%0d", tag, b), 64'(io_slave_rid), 64'(id));
            chk($sformatf("%s rresp b%0d", tag, b), 64'(io_slave_rresp), 64'd0);
            if (io_slave_rready === 1'b1 && io_slave_rvalid === 1'b1) b++;
            @(negedge clock);
            cyc++;
        end
        io_slave_rready = 1'b0;
        chk({tag, " beats_done"}, 64'(b), 64'(len + 1));
        chk({tag, " rvalid_drop"}, 64'(io_slave_rvalid), 64'd0);
        chk({tag, " arready_back"}, 64'(io_slave_arready), 64'd1);
        $display("READ  %s idx=%0d len=%0d stall=%0d cycles=%0d", tag, idx, len, stall, cyc);
    endtask

    initial begin
        logic [63:0] d;
        int base;
        int len;
        io_slave_awvalid = 1'b0; io_slave_awaddr = '0; io_slave_awid = '0; io_slave_awlen = '0;
        io_slave_wvalid = 1'b0; io_slave_wdata = '0; io_slave_wstrb = '0; io_slave_wlast = 1'b0;
        io_slave_bready = 1'b0; io_slave_arvalid = 1'b0; io_slave_araddr = '0; io_slave_arid = '0;
        io_slave_arlen = '0; io_slave_rready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst awready", 64'(io_slave_awready), 64'd0);
        chk("rst arready", 64'(io_slave_arready), 64'd0);
        chk("rst rvalid", 64'(io_slave_rvalid), 64'd0);
        chk("rst bvalid", 64'(io_slave_bvalid), 64'd0);
        chk("rst wready", 64'(io_slave_wready), 64'd0);
        chk("rst rlast", 64'(io_slave_rlast), 64'd0);
        chk("rst bresp", 64'(io_slave_bresp), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst awready", 64'(io_slave_awready), 64'd1);
        chk("post_rst arready", 64'(io_slave_arready), 64'd1);

        // 200-beat burst of beat indices, read back unstalled
        do_write(32'h0, 4'h3, 199, 200, 8'hFF, 0, "s1w");
        do_read(32'h0, 4'h9, 199, 1'b0, "s1r");

        // Partial-strobe write over a zeroed word
        do_write(waddr(5), 4'h1, 0, 1, 8'hFF, 2, "s2clr");
        do_write(waddr(5), 4'h2, 0, 1, 8'h0F, 3, "s2w");
        do_read(waddr(5), 4'h4, 0, 1'b0, "s2r");

        // Last word wraps to word 0; high and low address bits ignored
        do_write(waddr(DEPTH - 1), 4'h5, 0, 1, 8'hFF, 1, "s3w");
        do_read(32'h8000_0000 | waddr(DEPTH - 1) | 32'h3, 4'h7, 1, 1'b0, "s3r");

        // Short and overrun bursts
        do_write(waddr(300), 4'hB, 1, 1, 8'hFF, 1, "s4short");
        do_write(waddr(310), 4'hC, 2, 3, 8'hFF, 1, "s4fill");
        do_write(waddr(310), 4'hD, 0, 3, 8'hFF, 1, "s4over");
        do_read(waddr(300), 4'hE, 12, 1'b0, "s4r");

        // Stalled read
        do_read(waddr(0), 4'h8, 31, 1'b1, "s5r");

        // Reset mid-burst with concurrent read and write
        do_write(waddr(1000), 4'h2, 15, 16, 8'hFF, 1, "s6fill");
        @(negedge clock);
        io_slave_arvalid = 1'b1; io_slave_araddr = waddr(20); io_slave_arid = 4'h6; io_slave_arlen = 8'd15;
        io_slave_awvalid = 1'b1; io_slave_awaddr = waddr(1000); io_slave_awid = 4'hA; io_slave_awlen = 8'd15;
        chk("s6 arready", 64'(io_slave_arready), 64'd1);
        chk("s6 awready", 64'(io_slave_awready), 64'd1);
        @(negedge clock);
        io_slave_arvalid = 1'b0;
        io_slave_awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            d = {$urandom, $urandom};
            io_slave_wvalid = 1'b1; io_slave_wdata = d; io_slave_wstrb = 8'hFF; io_slave_wlast = 1'b0;
            io_slave_rready = 1'b1;
            chk($sformatf("s6 wready b%0d", b), 64'(io_slave_wready), 64'd1);
            chk($sformatf("s6 rvalid b%0d", b), 64'(io_slave_rvalid), 64'd1);
            chk($sformatf("s6 rdata b%0d", b), io_slave_rdata, mget(20 + b));
            mput(1000 + b, d, 8'hFF);
            @(negedge clock);
        end
        reset = 1'b1;
        io_slave_wvalid = 1'b0;
        @(negedge clock);
        io_slave_rready = 1'b0;
        chk("s6 rst rvalid", 64'(io_slave_rvalid), 64'd0);
        chk("s6 rst bvalid", 64'(io_slave_bvalid), 64'd0);
        chk("s6 rst wready", 64'(io_slave_wready), 64'd0);
        chk("s6 rst arready", 64'(io_slave_arready), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("s6 rel awready", 64'(io_slave_awready), 64'd1);
        chk("s6 rel arready", 64'(io_slave_arready), 64'd1);
        $display("RESET s6 mid-burst pulse done");
        do_read(waddr(1000), 4'h3, 15, 1'b0, "s6r");
        do_write(waddr(2000), 4'hF, 7, 8, 8'hFF, 1, "s6w2");
        do_read(waddr(2000), 4'h1, 7, 1'b1, "s6r2");

        // Randomized bursts: full fill, partial-strobe overwrite, read back
        for (int n = 0; n < 6; n++) begin
            base = int'($urandom_range(3000, 8000));
            len  = int'($urandom_range(0, 15));
            do_write(waddr(base), 4'($urandom_range(0, 15)), len, len + 1, 8'hFF, 1, $sformatf("rnd%0d_fill", n));
            do_write(waddr(base), 4'($urandom_range(0, 15)), len, len + 1, 8'($urandom_range(0, 255)), 1,
                     $sformatf("rnd%0d_part", n));
            do_read(waddr(base), 4'($urandom_range(0, 15)), len, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_rd", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
